// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and helpers for the cached integer register file.
package ibex_pkg;

  localparam int unsigned RfDataWidth = 32;
  localparam int unsigned RfAddrWidth = 5;

  // Fill sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_A = 2'd1,
    FILL_B = 2'd2
  } rf_fill_state_e;

  // One L1 entry; the data field is sized by RfDataWidth, so the top-level
  // DataWidth parameter is expected to match it.
  typedef struct packed {
    logic                   valid;
    logic [RfAddrWidth-1:0] tag;
    logic [RfDataWidth-1:0] data;
  } rf_l1_entry_t;

  // RV32E only has 16 registers, so address bit 4 carries no information.
  function automatic logic [RfAddrWidth-1:0] rf_norm_addr(input logic rv32e,
                                                          input logic [RfAddrWidth-1:0] addr);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/ibex_rf_l2_store.sv
// ibex_rf_l2_store: full architectural register state, 1R1W flop array with
// a registered read port (read-during-write returns the old word).
module ibex_rf_l2_store
  import ibex_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = RfDataWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_re,
  input  logic [RfAddrWidth-1:0] i_raddr,
  output logic [DataWidth-1:0]   o_rdata,
  input  logic                   i_we,
  input  logic [RfAddrWidth-1:0] i_waddr,
  input  logic [DataWidth-1:0]   i_wdata
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam int unsigned IdxWidth = RV32E ? 4 : 5;

  logic [DataWidth-1:0] r_mem [NumWords];
  logic [DataWidth-1:0] r_rdata;
  logic [IdxWidth-1:0]  w_ridx;
  logic [IdxWidth-1:0]  w_widx;

  assign w_ridx  = i_raddr[IdxWidth-1:0];
  assign w_widx  = i_waddr[IdxWidth-1:0];
  assign o_rdata = r_rdata;

  // Storage write and registered read; both use pre-edge contents
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[w_widx] <= i_wdata;
      if (i_re) r_rdata <= r_mem[w_ridx];
    end
  end

endmodule

// File: rtl/ibex_register_file_cached.sv
// ibex_register_file_cached: fully-associative flop L1 in front of a 1R1W L2
// holding the architectural state. Misses stall decode while a fill sequencer
// loads operand A then B from L2. Writes go through to L2 and update L1 on hit.
// Optional performance counters: define IBEX_RF_CACHE_PERF_EN.
module ibex_register_file_cached
  import ibex_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = RfDataWidth,
  parameter int unsigned L1Entries = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rd_req_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 we_a_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic [31:0]          perf_access_o,
  output logic [31:0]          perf_miss_o
);

  localparam int unsigned PtrWidth = $clog2(L1Entries);

  rf_l1_entry_t         r_l1 [L1Entries];
  rf_fill_state_e       r_state;
  rf_fill_state_e       w_state_next;
  logic [PtrWidth-1:0]  r_ptr;
  logic [4:0]           r_fill_tag;
  logic                 r_fwd_valid;
  logic [DataWidth-1:0] r_fwd_data;

  logic [4:0]           w_addr_a, w_addr_b, w_waddr;
  logic                 w_we, w_hit_a, w_hit_b, w_b_after_a;
  logic [L1Entries-1:0] w_match_a, w_match_b, w_match_w, w_match_f, w_alloc_sel;
  logic [DataWidth-1:0] w_rdata_a, w_rdata_b, w_fill_data, w_l2_rdata;
  logic                 w_l2_re, w_alloc;
  logic [4:0]           w_l2_raddr;
  logic [PtrWidth-1:0]  w_alloc_idx;

  assign w_addr_a    = rf_norm_addr(RV32E, raddr_a_i);
  assign w_addr_b    = rf_norm_addr(RV32E, raddr_b_i);
  assign w_waddr     = rf_norm_addr(RV32E, waddr_a_i);
  assign w_we        = we_a_i & (w_waddr != 5'd0);

  // Per-entry tag comparators for both read ports, the write port and the fill
  for (genvar gi = 0; gi < L1Entries; gi++) begin : g_match
    assign w_match_a[gi]   = r_l1[gi].valid & (r_l1[gi].tag == w_addr_a);
    assign w_match_b[gi]   = r_l1[gi].valid & (r_l1[gi].tag == w_addr_b);
    assign w_match_w[gi]   = r_l1[gi].valid & (r_l1[gi].tag == w_waddr);
    assign w_match_f[gi]   = r_l1[gi].valid & (r_l1[gi].tag == r_fill_tag);
    assign w_alloc_sel[gi] = w_alloc & (w_alloc_idx == PtrWidth'(gi));
  end

  // x0 always hits; otherwise a hit needs a valid matching entry
  assign w_hit_a     = (w_addr_a == 5'd0) | (|w_match_a);
  assign w_hit_b     = (w_addr_b == 5'd0) | (|w_match_b);
  assign w_b_after_a = ~w_hit_b & (w_addr_b != r_fill_tag);
  assign rdata_a_o   = w_rdata_a;
  assign rdata_b_o   = w_rdata_b;

  // Newest data wins: a write in the fill cycle, then a write that raced the
  // L2 read issue (L2 returns the old word in that case), then L2.
  assign w_fill_data = (w_we && (w_waddr == r_fill_tag)) ? wdata_a_i :
                       (r_fwd_valid ? r_fwd_data : w_l2_rdata);

  // Operand read mux; tags are unique so at most one entry matches
  always_comb begin
    w_rdata_a = '0;
    w_rdata_b = '0;
    for (int i = 0; i < L1Entries; i++) begin
      if (w_match_a[i]) w_rdata_a = DataWidth'(r_l1[i].data);
      if (w_match_b[i]) w_rdata_b = DataWidth'(r_l1[i].data);
    end
    if (w_addr_a == 5'd0) w_rdata_a = '0;
    if (w_addr_b == 5'd0) w_rdata_b = '0;
  end

  // Allocation target: reuse an entry already holding the fill tag, else the victim
  always_comb begin
    w_alloc_idx = r_ptr;
    for (int i = 0; i < L1Entries; i++) begin
      if (w_match_f[i]) w_alloc_idx = PtrWidth'(i);
    end
  end

  // Fill sequencer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Fill sequencer next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (rd_req_i && !w_hit_a)      w_state_next = FILL_A;
        else if (rd_req_i && !w_hit_b) w_state_next = FILL_B;
      end
      FILL_A:  w_state_next = w_b_after_a ? FILL_B : IDLE;
      FILL_B:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Fill sequencer outputs: L2 read issue, allocation strobe, decode stall
  always_comb begin
    w_l2_re    = 1'b0;
    w_l2_raddr = w_addr_a;
    w_alloc    = (r_state != IDLE);
    stall_o    = (r_state != IDLE) | (rd_req_i & ~(w_hit_a & w_hit_b));
    case (r_state)
      IDLE: begin
        if (rd_req_i && !w_hit_a) begin
          w_l2_re = 1'b1;
        end else if (rd_req_i && !w_hit_b) begin
          w_l2_re    = 1'b1;
          w_l2_raddr = w_addr_b;
        end
      end
      FILL_A: begin
        if (w_b_after_a) begin
          w_l2_re    = 1'b1;
          w_l2_raddr = w_addr_b;
        end
      end
      default: ;
    endcase
  end

  // Remember the address being fetched and any write that races its issue
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fill_tag  <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_data  <= '0;
    end else if (w_l2_re) begin
      r_fill_tag  <= w_l2_raddr;
      r_fwd_valid <= w_we & (w_waddr == w_l2_raddr);
      r_fwd_data  <= wdata_a_i;
    end
  end

  // L1 entries: flush, allocation (overrides flush for its entry), write-hit update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < L1Entries; i++) r_l1[i] <= '0;
      r_ptr <= '0;
    end else begin
      for (int i = 0; i < L1Entries; i++) begin
        if (flush_i) r_l1[i].valid <= 1'b0;
        if (w_alloc_sel[i]) begin
          r_l1[i].valid <= 1'b1;
          r_l1[i].tag   <= r_fill_tag;
          r_l1[i].data  <= RfDataWidth'(w_fill_data);
        end else if (w_we && w_match_w[i]) begin
          r_l1[i].data  <= RfDataWidth'(wdata_a_i);
        end
      end
      if (w_alloc) r_ptr <= r_ptr + PtrWidth'(1);
    end
  end

  ibex_rf_l2_store #(
    .RV32E    (RV32E),
    .DataWidth(DataWidth)
  ) u_l2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_re   (w_l2_re),
    .i_raddr(w_l2_raddr),
    .o_rdata(w_l2_rdata),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(wdata_a_i)
  );

`ifdef IBEX_RF_CACHE_PERF_EN
  logic [31:0] r_perf_access;
  logic [31:0] r_perf_miss;

  // Saturating lookup and fill counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_access <= '0;
      r_perf_miss   <= '0;
    end else begin
      if ((r_state == IDLE) && rd_req_i && (r_perf_access != 32'hFFFF_FFFF))
        r_perf_access <= r_perf_access + 32'd1;
      if ((r_state != IDLE) && (r_perf_miss != 32'hFFFF_FFFF))
        r_perf_miss <= r_perf_miss + 32'd1;
    end
  end

  assign perf_access_o = r_perf_access;
  assign perf_miss_o   = r_perf_miss;
`else
  assign perf_access_o = '0;
  assign perf_miss_o   = '0;
`endif

endmodule

// File: doc/ibex_register_file_cached.md
# ibex_register_file_cached

Two-level integer register file for the Ibex decode stage. A small, fully-associative, parametrised L1 of flop entries holds recently used architectural registers. A 1R1W L2 store holds the full architectural state. L1 misses are filled from L2 by a fill FSM that stalls decode until both operands hit. Writes are write-through, so eviction never needs a writeback.

## Interface
Parameters:
- RV32E, 0, 1 selects 16 architectural registers; 0 selects 32.
- DataWidth, 32, register width in bits.
- L1Entries, 4, number of L1 entries; power of two, range 2..8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- rd_req_i  in  1  decode presents valid operand addresses this cycle.
- raddr_a_i  in  5  operand A address.
- raddr_b_i  in  5  operand B address.
- rdata_a_o  out  DataWidth  operand A data; valid when rd_req_i=1 and stall_o=0.
- rdata_b_o  out  DataWidth  operand B data; same validity rule as A.
- waddr_a_i  in  5  write address.
- wdata_a_i  in  DataWidth  write data.
- we_a_i  in  1  write enable.
- flush_i  in  1  invalidate all L1 entries.
- stall_o  out  1  operands not yet available; decode must hold.
- perf_access_o  out  32  count of lookup cycles.
- perf_miss_o  out  32  count of L2 fills.

## Operation
- x0 reads 0 and always hits. x0 is never allocated. Writes to x0 are dropped.
- With RV32E=1, address bit 4 is ignored.
- Each L1 entry holds a valid bit, a 5-bit tag and a data word. Lookup compares the tag against all valid entries, combinationally, per port.
- Write: L2 is always written. A hit L1 entry is updated at the same edge. A write miss does not allocate.
- FSM states:
  - IDLE: if rd_req_i=1 and A misses, issue an L2 read of raddr_a_i and go to FILL_A. Else if B misses, issue an L2 read of raddr_b_i and go to FILL_B.
  - FILL_A: allocate the L2 read data into the victim entry. If B misses, and raddr_b_i differs from the address just filled, issue an L2 read of B and go to FILL_B. Otherwise go to IDLE.
  - FILL_B: allocate into the victim entry, then go to IDLE.
- Victim selection: a round-robin pointer, advanced on every allocation. L1Entries≥2 guarantees that a B fill never evicts the A entry filled in the same sequence.
- Fill forwarding: if we_a_i=1 and waddr_a_i equals the fill tag in a FILL cycle, the allocated entry takes wdata_a_i, not the stale L2 data.
- An allocation whose tag is already valid in L1 (a write-hit race) overwrites that existing entry. No duplicate tags are ever created.
- Fills are not aborted. rd_req_i dropping mid-fill still completes the fill.
- flush_i clears all valid bits at the edge. An allocation at the same edge is still performed, so that entry remains valid.
- The round-robin pointer is not reset by flush_i.

## Timing
- Reset values:
  - All L1 valid bits 0, pointer 0, state IDLE.
  - All L2 words 0.
  - stall_o=0, perf counters 0.
  - rdata_a_o/rdata_b_o read 0 for address 0; otherwise the IDLE miss path drives 0.
- stall_o = (rd_req_i & any miss & state==IDLE) | (state!=IDLE). stall_o is combinational.
- L2 read latency is 1 cycle: address in cycle N, data in cycle N+1.
- Single miss: stall in cycles 0–1, hit with data in cycle 2.
- Double miss: stall in cycles 0–2, data in cycle 3.
- Both ports missing on the same register: treated as a single miss.
- Reset asserted mid-fill: everything returns to reset state immediately. No partial allocation survives.

## Configuration
- IBEX_RF_CACHE_PERF_EN defined:
  - perf_access_o increments on every IDLE cycle with rd_req_i=1.
  - perf_miss_o increments on every FILL_A or FILL_B cycle.
  - Both counters saturate at 32'hFFFF_FFFF.
- IBEX_RF_CACHE_PERF_EN undefined: both ports tie to 0 and no counter flops exist.

## Structure
- ibex_pkg carries:
  - the FSM enum rf_fill_state_e (IDLE, FILL_A, FILL_B);
  - the entry struct rf_l1_entry_t (valid, tag, data).
- Sub-module ibex_rf_l2_store: a 1R1W flop array, RV32E-sized.
  - Synchronous registered read.
  - Read-during-write to the same address returns old data.
  - Reset to 0.

## Test plan
- Reset, then write x5=0xDEAD_BEEF; next cycle read A=x5 → stall_o high 2 cycles, rdata_a_o=0xDEAD_BEEF in cycle 2, perf_miss_o=1.
- Read A=x7, B=x9, both cold → stall_o high 3 cycles, then both data correct. An immediate re-read of x7/x9 hits with stall_o=0.
- Read A=B=x3 cold → exactly one fill, stall_o high 2 cycles.
- L1Entries=4: fill x1..x5 in sequence, then read x1 → miss (evicted by round-robin). Read x5 → hit.
- During FILL_A of x6, write x6=0x1234 → the entry holds 0x1234 and the subsequent read returns 0x1234.
- Assert flush_i after x8 is cached → the next read of x8 stalls 2 cycles. Reading x0 never stalls and returns 0.
